// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the OBI main-memory arbiter.
// Round-robin picker is sized for up to RR_MAX_REQ requesters.
package mem_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int unsigned REQ_ICACHE = 0;
   localparam int unsigned REQ_DCACHE = 1;
   localparam int unsigned REQ_VPU    = 2;

   localparam int unsigned RR_MAX_REQ = 16;

   // First set bit of req at or after ptr, wrapping modulo num; returns ptr when req is empty.
   function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                           input int unsigned ptr,
                                           input int unsigned num);
      logic [31:0] idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
         idx = ptr + i;
         if (idx >= num) idx = idx - num;
         if (i < num && !found && req[idx[3:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mem_arb_route_fifo.sv
// Synchronous FIFO holding the requester index of each outstanding transaction.
module mem_arb_route_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // Entry storage carries no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin OBI arbiter with burst lock sharing one main-memory port; responses routed by FIFO.
// Optional per-port grant/wait counters are built when ARB_PERF_CNT_EN is defined.
module obi_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_OUTST  = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
`ifdef ARB_PERF_CNT_EN
   output logic [NUM_REQ-1:0][31:0]              perf_gnt_cnt_o,
   output logic [NUM_REQ-1:0][31:0]              perf_wait_cnt_o,
`endif
   input  logic [NUM_REQ-1:0]                    req_i,
   output logic [NUM_REQ-1:0]                    gnt_o,
   input  logic [NUM_REQ-1:0]                    lock_i,
   input  logic [NUM_REQ-1:0]                    we_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  be_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
   output logic [NUM_REQ-1:0]                    rvalid_o,
   output logic [DATA_WIDTH-1:0]                 rdata_o,
   output logic                                  mem_req_o,
   input  logic                                  mem_gnt_i,
   output logic                                  mem_we_o,
   output logic [DATA_WIDTH/8-1:0]               mem_be_o,
   output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
   output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
   input  logic                                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t         state_q;
   logic [IDX_W-1:0]   owner_q, rr_ptr_q, winner, rr_next, head;
   logic [NUM_REQ-1:0] eligible;
   logic               fifo_full, fifo_empty, accept, resp_ok;

   always_comb begin
      eligible = req_i;
      if (state_q == ARB_LOCKED) eligible = req_i & (NUM_REQ'(1) << owner_q);
   end

   assign winner  = IDX_W'(rr_pick(RR_MAX_REQ'(eligible), 32'(rr_ptr_q), NUM_REQ));
   assign rr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   // Full is judged on current occupancy, so a same-cycle response never frees a slot early.
   assign mem_req_o = !rst_i && (|eligible) && !fifo_full;
   assign accept    = mem_req_o && mem_gnt_i;

   always_comb begin
      gnt_o = '0;
      if (accept) gnt_o[winner] = 1'b1;
   end

   assign mem_we_o    = we_i[winner];
   assign mem_be_o    = be_i[winner];
   assign mem_addr_o  = addr_i[winner];
   assign mem_wdata_o = wdata_i[winner];

   // A response with nothing outstanding is dropped rather than misrouted.
   assign resp_ok = !rst_i && mem_rvalid_i && !fifo_empty;
   assign rdata_o = mem_rdata_i;

   always_comb begin
      rvalid_o = '0;
      if (resp_ok) rvalid_o[head] = 1'b1;
   end

   mem_arb_route_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (IDX_W)
   ) u_route_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .data_i  (winner),
      .pop_i   (resp_ok),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ARB_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (accept) begin
                  rr_ptr_q <= rr_next;
                  if (lock_i[winner]) begin
                     state_q <= ARB_LOCKED;
                     owner_q <= winner;
                  end
               end
            end
            ARB_LOCKED: begin
               // Pointer stays frozen for the burst and moves on the beat that releases it.
               if (accept) begin
                  if (!lock_i[owner_q]) begin
                     state_q  <= ARB_IDLE;
                     rr_ptr_q <= rr_next;
                  end
               end else if (!req_i[owner_q] && !lock_i[owner_q]) begin
                  state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(mem_rvalid_i && fifo_empty))
            else $warning("obi_mem_arbiter: response with no outstanding transaction dropped");
      end
   end
`endif

`ifdef ARB_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_gnt_cnt_o  <= '0;
         perf_wait_cnt_o <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k])             perf_gnt_cnt_o[k]  <= sat_inc(perf_gnt_cnt_o[k]);
            if (req_i[k] && !gnt_o[k]) perf_wait_cnt_o[k] <= sat_inc(perf_wait_cnt_o[k]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter; response routing checked through a scoreboard queue.
module tb_obi_mem_arbiter;
   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                       clk_i, rst_i;
   logic [NR-1:0]              req_i, gnt_o, lock_i, we_i, rvalid_o;
   logic [NR-1:0][DW/8-1:0]    be_i;
   logic [NR-1:0][AW-1:0]      addr_i;
   logic [NR-1:0][DW-1:0]      wdata_i;
   logic [DW-1:0]              rdata_o, mem_rdata_i, mem_wdata_o;
   logic                       mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
   logic [DW/8-1:0]            mem_be_o;
   logic [AW-1:0]              mem_addr_o;
`ifdef ARB_PERF_CNT_EN
   logic [NR-1:0][31:0]        perf_gnt_cnt_o, perf_wait_cnt_o;
`endif

   int checks = 0;
   int errors = 0;
   int sb[$];

   obi_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
`ifdef ARB_PERF_CNT_EN
      .perf_gnt_cnt_o  (perf_gnt_cnt_o),
      .perf_wait_cnt_o (perf_wait_cnt_o),
`endif
      .req_i        (req_i),
      .gnt_o        (gnt_o),
      .lock_i       (lock_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] addr_of(input int k);
      return 32'h1000_0000 + (k << 8);
   endfunction

   function automatic int idx_of(input logic [NR-1:0] g);
      for (int k = 0; k < NR; k++) if (g[k]) return k;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive at negedge, check combinational outputs before the next posedge.
   task automatic cyc(input logic [NR-1:0] req, input logic [NR-1:0] lock, input logic rv,
                      input logic [DW-1:0] rd, input logic [NR-1:0] exp_g, input string tag);
      int e;
      @(negedge clk_i);
      req_i = req; lock_i = lock; mem_rvalid_i = rv; mem_rdata_i = rd; mem_gnt_i = 1'b1;
      #1;
      chk({tag, "_gnt"}, 64'(gnt_o), 64'(exp_g));
      if (rv) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk({tag, "_rvalid"}, 64'(rvalid_o), 64'(3'b001 << e));
            chk({tag, "_rdata"}, 64'(rdata_o), 64'(rd));
         end
      end else begin
         chk({tag, "_rvalid0"}, 64'(rvalid_o), 64'd0);
      end
      if (exp_g != '0) begin
         chk({tag, "_addr"}, 64'(mem_addr_o), 64'(addr_of(idx_of(exp_g))));
         sb.push_back(idx_of(exp_g));
      end
   endtask

   initial begin
      rst_i = 1'b1; req_i = '0; lock_i = '0; we_i = '0; mem_gnt_i = 1'b1;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      for (int k = 0; k < NR; k++) begin
         be_i[k] = '1; addr_i[k] = addr_of(k); wdata_i[k] = 32'hC0DE_0000 + k;
      end

      // Reset state, with requests and a response pending on the inputs.
      @(negedge clk_i);
      req_i = 3'b111; mem_rvalid_i = 1'b1;
      #1;
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_memreq", 64'(mem_req_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0; req_i = '0; mem_rvalid_i = 1'b0;

      // Round-robin with all ports requesting, one-cycle response.
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b001, "rr0");
      cyc(3'b111, 3'b000, 1'b1, 32'h1111_0000, 3'b010, "rr1");
      cyc(3'b111, 3'b000, 1'b1, 32'h1111_0001, 3'b100, "rr2");
      cyc(3'b111, 3'b000, 1'b1, 32'h1111_0002, 3'b001, "rr3");
      cyc(3'b111, 3'b000, 1'b1, 32'h1111_0003, 3'b010, "rr4");
      cyc(3'b111, 3'b000, 1'b1, 32'h1111_0004, 3'b100, "rr5");
      cyc(3'b000, 3'b000, 1'b1, 32'h1111_0005, 3'b000, "rr6");

      // Port 1 burst lock while ports 0 and 2 also request.
      cyc(3'b010, 3'b010, 1'b0, 32'h0,         3'b010, "lk0");
      cyc(3'b111, 3'b010, 1'b1, 32'h2222_0000, 3'b010, "lk1");
      cyc(3'b111, 3'b010, 1'b1, 32'h2222_0001, 3'b010, "lk2");
      cyc(3'b111, 3'b000, 1'b1, 32'h2222_0002, 3'b010, "lk3");
      cyc(3'b101, 3'b000, 1'b1, 32'h2222_0003, 3'b100, "lk4");
      cyc(3'b001, 3'b000, 1'b1, 32'h2222_0004, 3'b001, "lk5");
      cyc(3'b000, 3'b000, 1'b1, 32'h2222_0005, 3'b000, "lk6");

      // Outstanding limit: four grants, then none, including at full with a pop.
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b010, "fl0");
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b100, "fl1");
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b001, "fl2");
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b010, "fl3");
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b000, "fl4");
      chk("fl4_memreq", 64'(mem_req_o), 64'd0);
      cyc(3'b111, 3'b000, 1'b1, 32'h3333_0000, 3'b000, "fl5");
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b100, "fl6");
      cyc(3'b000, 3'b000, 1'b1, 32'h3333_0001, 3'b000, "fl7");
      cyc(3'b000, 3'b000, 1'b1, 32'h3333_0002, 3'b000, "fl8");
      cyc(3'b000, 3'b000, 1'b1, 32'h3333_0003, 3'b000, "fl9");
      cyc(3'b000, 3'b000, 1'b1, 32'h3333_0004, 3'b000, "fl10");

      // Responses follow grant order 2 then 0.
      cyc(3'b100, 3'b000, 1'b0, 32'h0,         3'b100, "oo0");
      cyc(3'b001, 3'b000, 1'b0, 32'h0,         3'b001, "oo1");
      cyc(3'b000, 3'b000, 1'b1, 32'hAAAA_0002, 3'b000, "oo2");
      cyc(3'b000, 3'b000, 1'b1, 32'hBBBB_0000, 3'b000, "oo3");

      // Reset while locked with two outstanding.
      cyc(3'b010, 3'b010, 1'b0, 32'h0,         3'b010, "mr0");
      cyc(3'b010, 3'b010, 1'b0, 32'h0,         3'b010, "mr1");
      @(negedge clk_i);
      rst_i = 1'b1; req_i = 3'b111; lock_i = 3'b010; mem_rvalid_i = 1'b1;
      #1;
      chk("mr_rst_gnt", 64'(gnt_o), 64'd0);
      chk("mr_rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("mr_rst_memreq", 64'(mem_req_o), 64'd0);
      sb.delete();
      @(negedge clk_i);
      rst_i = 1'b0; req_i = '0; lock_i = '0; mem_rvalid_i = 1'b0;
      @(negedge clk_i);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("mr_stray_rvalid", 64'(rvalid_o), 64'd0);
      cyc(3'b111, 3'b000, 1'b0, 32'h0,         3'b001, "mr2");
      cyc(3'b000, 3'b000, 1'b1, 32'h4444_0000, 3'b000, "mr3");

`ifdef ARB_PERF_CNT_EN
      @(negedge clk_i);
      rst_i = 1'b1; req_i = '0; mem_rvalid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cyc(3'b111, 3'b000, i > 0, 32'hD000_0000 + i, 3'(3'b001 << (i % 3)), "pc");
         if (i == 3) chk("pc_wait2_first", 64'(perf_wait_cnt_o[2]), 64'd2);
      end
      cyc(3'b000, 3'b000, 1'b1, 32'hD000_0030, 3'b000, "pc_drain");
      for (int k = 0; k < NR; k++) begin
         chk($sformatf("pc_gnt%0d", k), 64'(perf_gnt_cnt_o[k]), 64'd10);
         chk($sformatf("pc_wait%0d", k), 64'(perf_wait_cnt_o[k]), 64'd20);
      end
`endif

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
